ex_muldiv_ctrl: RTL and testbench
=================================

// Module: ex_muldiv_ctrl
// PURPOSE
// - Multi-cycle RV32M multiply/divide sequencer beside the EX stage ALU; owns an iterative
//   shift-add multiplier and a restoring divider, and stalls the pipeline while busy.
// - Receives operands from the EX operand muxes plus funct3; returns one result to the EX
//   result mux with a one-cycle valid pulse. Single-cycle ALU ops never touch this block.
// PARAMETERS
// - XLEN   32   operand/result width; even, >= 8; iteration count = XLEN
// PORTS
// - cpu_clk       in   1     clock, rising edge
// - cpu_rst       in   1     asynchronous, active-high reset
// - md_req        in   1     EX holds a M-extension instruction (level, held while stalled)
// - md_op         in   3     funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
// - md_a          in   XLEN  rs1 operand (EX operand A)
// - md_b          in   XLEN  rs2 operand (never the sign-extended immediate)
// - md_flush      in   1     pipeline flush; used only with MULDIV_FLUSH_EN
// - md_stall      out  1     freeze PC/IF/ID/ID-EX registers this cycle
// - md_valid      out  1     one-cycle pulse: md_result valid, EX may retire
// - md_result     out  XLEN  result, held until next accept
// BEHAVIOUR
// - Reset (async): state IDLE, counter 0, md_valid 0, md_result 0, internal regs 0.
// - FSM IDLE -> CALC -> DONE -> IDLE. md_stall = (IDLE & md_req) | CALC (combinational).
// - IDLE, md_req=1: accept; latch op, |a|, |b|, result sign; clear 2*XLEN accumulator,
//   counter=0; -> CALC. Exception: special divide case -> DONE directly (see below).
// - CALC: one mul or div step per cycle; counter increments; after step XLEN-1 -> DONE.
// - DONE: md_valid=1, md_stall=0 (pipeline advances, same instr leaves EX); -> IDLE.
//   md_req still high in DONE is NOT re-accepted. Back-to-back: next req accepted in IDLE.
// - Latency: accept cycle T, md_valid at T+XLEN+1 (T+33 at XLEN=32); special case T+1.
// - Multiply: unsigned shift-add on magnitudes; product negated if sign set.
//   Sign: MUL/MULH a^b signed; MULHSU a only; MULHU none. MUL -> low half, others high.
// - Divide: restoring, magnitudes; quotient sign a^b, remainder sign = sign of a.
// - Special divide cases (decided at accept, always handled):
//   b==0: DIV/DIVU -> all ones; REM/REMU -> a.
//   DIV/REM with a==100..0, b==all ones: DIV -> a, REM -> 0.
// - md_op/md_a/md_b only sampled at accept; changes during CALC ignored.
// - Reset mid-operation: immediate return to IDLE, no md_valid, md_stall drops async.
// CONFIGURATION
// - MULDIV_FLUSH_EN defined: md_flush=1 in CALC or DONE -> IDLE next edge, md_valid
//   forced 0 that cycle, md_stall 0 that cycle; md_result keeps previous value.
//   md_flush with md_req in IDLE: no accept.
// - MULDIV_FLUSH_EN undefined: md_flush ignored; every accepted op completes and pulses.
// TESTING
// - MUL 7 x -3 -> md_result 0xFFFFFFEB, md_valid at T+33, md_stall high T..T+32, low T+33.
// - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000;
//   MULHSU a=-1 b=0xFFFFFFFF -> 0xFFFFFFFF.
// - DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
// - DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000,
//   REM same -> 0; each md_valid at T+1, stall only in cycle T.
// - Back-to-back: req held through DONE then new op next cycle -> exactly two md_valid
//   pulses, no duplicate accept; cpu_rst pulsed at CALC cycle 10 -> IDLE, no md_valid.
// - MULDIV_FLUSH_EN: flush at CALC cycle 5 -> IDLE next edge, no md_valid, stall low;
//   without macro same stimulus completes with md_valid at T+33.

Source files
------------

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative RV32M multiply/divide sequencer beside the EX ALU; stalls the pipe while busy.
// Optional feature macro MULDIV_FLUSH_EN: md_flush aborts CALC/DONE and blocks an accept in IDLE.
module ex_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            md_req,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] md_a,
  input  logic [XLEN-1:0] md_b,
  input  logic            md_flush,
  output logic            md_stall,
  output logic            md_valid,
  output logic [XLEN-1:0] md_result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: md_req is a level held by EX; an op is taken in IDLE when md_req=1, md_stall
  // holds the front end until DONE, where md_valid pulses for exactly one cycle and EX retires.
  // A request still high in DONE belongs to the retiring instruction and is never re-taken.

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          op_q;
  logic                sign_q;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   mcand;
  logic [XLEN-1:0]     mplier;
  logic [XLEN-1:0]     res_pend;
  logic [XLEN-1:0]     res_hold;
  logic                flush;

`ifdef MULDIV_FLUSH_EN
  assign flush = md_flush;
`else
  assign flush = md_flush & 1'b0;
`endif

  // Accept-side decode of operand signedness, magnitudes and the divide corner cases.
  logic            a_signed, b_signed, a_neg, b_neg, is_div;
  logic            div_zero, div_ovf, special, res_sign;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (md_op)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2:    a_signed = 1'b1;
      default: ;
    endcase
    is_div      = md_op[2];
    a_neg       = a_signed & md_a[XLEN-1];
    b_neg       = b_signed & md_b[XLEN-1];
    a_mag       = a_neg ? -md_a : md_a;
    b_mag       = b_neg ? -md_b : md_b;
    res_sign    = (md_op == 3'd6) ? a_neg : (a_neg ^ b_neg);
    div_zero    = is_div && (md_b == '0);
    div_ovf     = ((md_op == 3'd4) || (md_op == 3'd6)) && (md_a == MIN_NEG) && (md_b == ALL_ONE);
    special     = div_zero | div_ovf;
    special_res = '0;
    if (div_zero)     special_res = md_op[1] ? md_a : ALL_ONE;
    else if (div_ovf) special_res = md_op[1] ? '0 : md_a;
  end

  // One iteration: shift-add for multiply, restoring step for divide (acc = {rem, quot}).
  logic [2*XLEN-1:0] acc_nxt, mcand_nxt, prod;
  logic [XLEN-1:0]   mplier_nxt, quot, rem, final_res;
  logic [XLEN:0]     rem_sh, diff;
  logic              ge;

  always_comb begin
    rem_sh     = {acc[2*XLEN-1:XLEN], mplier[XLEN-1]};
    diff       = rem_sh - {1'b0, mcand[XLEN-1:0]};
    ge         = ~diff[XLEN];
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    if (op_q[2]) begin
      acc_nxt    = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], ge};
      mplier_nxt = mplier << 1;
    end else begin
      if (mplier[0]) acc_nxt = acc + mcand;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
    end
    prod = sign_q ? -acc_nxt : acc_nxt;
    quot = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1]) final_res = sign_q ? -rem : rem;
      else         final_res = sign_q ? -quot : quot;
    end else begin
      final_res = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      res_pend <= '0;
      res_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_req && !flush) begin
            op_q   <= md_op;
            sign_q <= res_sign;
            acc    <= '0;
            cnt    <= '0;
            if (special) begin
              res_pend <= special_res;
              state    <= DONE;
            end else begin
              mcand  <= {{XLEN{1'b0}}, (is_div ? b_mag : a_mag)};
              mplier <= is_div ? a_mag : b_mag;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              res_pend <= final_res;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          if (!flush) res_hold <= res_pend;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flushed DONE neither pulses nor exposes the abandoned result.
  assign md_valid  = (state == DONE) && !flush;
  assign md_result = ((state == DONE) && !flush) ? res_pend : res_hold;
  assign md_stall  = !cpu_rst && !flush && (((state == IDLE) && md_req) || (state == CALC));

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: scoreboard bench for ex_muldiv_ctrl (results, latency, stall, reset, flush).
// Define MULDIV_FLUSH_EN for both files to exercise the flush variant.
module tb_ex_muldiv_ctrl;
  localparam int XLEN = 32;

  logic            cpu_clk = 1'b0;
  logic            cpu_rst;
  logic            md_req;
  logic [2:0]      md_op;
  logic [XLEN-1:0] md_a;
  logic [XLEN-1:0] md_b;
  logic            md_flush;
  logic            md_stall;
  logic            md_valid;
  logic [XLEN-1:0] md_result;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  logic [XLEN-1:0] exp_q[$];

  ex_muldiv_ctrl #(.XLEN(XLEN)) dut (
    .cpu_clk  (cpu_clk),
    .cpu_rst  (cpu_rst),
    .md_req   (md_req),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_flush (md_flush),
    .md_stall (md_stall),
    .md_valid (md_valid),
    .md_result(md_result)
  );

  // clock / reset
  always #5 cpu_clk = ~cpu_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [63:0]     w;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; w = p; return w[31:0]; end
      3'd1: begin p = sa * sb; w = p; return w[63:32]; end
      3'd2: begin p = sa * longint'(ub); w = p; return w[63:32]; end
      3'd3: begin pu = ua * ub; w = pu; return w[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; w = p; return w[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; w = p; return w[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // scoreboard: every md_valid pops one expected result
  always @(negedge cpu_clk) begin
    if (!cpu_rst && md_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else check("result", md_result, exp_q.pop_front());
    end
  end

  // driver: issue one op, hold md_req, scramble operands after accept, time valid and stall
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int lat, seen;
    bit stall_ok;
    lat = model_lat(op, a, b);
    @(posedge cpu_clk); #1;
    md_req = 1'b1;
    md_op  = op;
    md_a   = a;
    md_b   = b;
    exp_q.push_back(model(op, a, b));
    seen     = -1;
    stall_ok = 1'b1;
    for (int k = 0; k <= lat; k++) begin
      @(negedge cpu_clk);
      if (md_valid && seen < 0) seen = k;
      if (md_stall !== (k < lat)) stall_ok = 1'b0;
      if (k == 0) begin
        @(posedge cpu_clk); #1;
        md_op = 3'($urandom_range(0, 7));
        md_a  = $urandom;
        md_b  = $urandom;
      end
    end
    check({tag, "_latency"}, 32'(seen), 32'(lat));
    check({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
  endtask

  task automatic go_idle();
    @(posedge cpu_clk); #1;
    md_req = 1'b0;
    repeat (3) @(negedge cpu_clk);
  endtask

  initial begin
    int v0, seen;
    int n_ops;
    cpu_rst  = 1'b1;
    md_req   = 1'b0;
    md_flush = 1'b0;
    md_op    = '0;
    md_a     = '0;
    md_b     = '0;

    @(negedge cpu_clk);
    check("reset_valid", {31'd0, md_valid}, 32'd0);
    check("reset_result", md_result, 32'd0);
    check("reset_stall", {31'd0, md_stall}, 32'd0);
    #1 md_req = 1'b1;
    #1 check("reset_stall_req", {31'd0, md_stall}, 32'd0);
    md_req = 1'b0;
    @(negedge cpu_clk);
    cpu_rst = 1'b0;

    // directed ops, issued back to back with md_req held through each DONE
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, "divu_100/7");
    run_op(3'd7, 32'd100, 32'd7, "remu_100/7");
    run_op(3'd4, 32'd5, 32'd0, "div_by0");
    run_op(3'd7, 32'd5, 32'd0, "remu_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    n_ops = 12;
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      run_op(rop, ra, rb, "rand");
      n_ops++;
    end
    go_idle();
    check("valid_count", 32'(valid_cnt), 32'(n_ops));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    // back-to-back pair: exactly two pulses, no duplicate accept
    v0 = valid_cnt;
    run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, "b2b_first");
    run_op(3'd5, 32'd1000, 32'd33, "b2b_second");
    go_idle();
    repeat (5) @(negedge cpu_clk);
    check("b2b_pulses", 32'(valid_cnt - v0), 32'd2);

    // reset in the middle of CALC
    v0 = valid_cnt;
    @(posedge cpu_clk); #1;
    md_req = 1'b1;
    md_op  = 3'd0;
    md_a   = 32'd1234;
    md_b   = 32'd5678;
    repeat (11) @(negedge cpu_clk);
    check("pre_rst_stall", {31'd0, md_stall}, 32'd1);
    #2 cpu_rst = 1'b1;
    #1 check("rst_stall_drop", {31'd0, md_stall}, 32'd0);
    md_req = 1'b0;
    @(negedge cpu_clk); #1;
    cpu_rst = 1'b0;
    check("rst_result_clear", md_result, 32'd0);
    repeat (40) @(negedge cpu_clk);
    check("rst_no_valid", 32'(valid_cnt - v0), 32'd0);

    // flush at CALC cycle 5
    v0 = valid_cnt;
    @(posedge cpu_clk); #1;
    md_req = 1'b1;
    md_op  = 3'd0;
    md_a   = 32'd123;
    md_b   = 32'hFFFF_FFD3;
`ifndef MULDIV_FLUSH_EN
    exp_q.push_back(model(3'd0, 32'd123, 32'hFFFF_FFD3));
`endif
    seen = -1;
    for (int k = 0; k <= 40; k++) begin
      @(negedge cpu_clk);
      if (md_valid && seen < 0) seen = k;
      if (k == 4) begin
        @(posedge cpu_clk); #1;
        md_flush = 1'b1;
        md_req   = 1'b0;
      end
      if (k == 5) begin
`ifdef MULDIV_FLUSH_EN
        check("flush_stall", {31'd0, md_stall}, 32'd0);
`else
        check("flush_stall", {31'd0, md_stall}, 32'd1);
`endif
        @(posedge cpu_clk); #1;
        md_flush = 1'b0;
      end
    end
`ifdef MULDIV_FLUSH_EN
    check("flush_no_valid", 32'(seen), 32'hFFFF_FFFF);
    check("flush_pulses", 32'(valid_cnt - v0), 32'd0);
`else
    check("flush_ignored_latency", 32'(seen), 32'(XLEN + 1));
    check("flush_ignored_pulses", 32'(valid_cnt - v0), 32'd1);
`endif
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
